// File: rtl/bus_pkg.sv
// Purpose: shared bus operation encodings, L2 opcodes and bus-master FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a.
package bus_pkg;

   typedef enum logic [1:0] {
      BUS_NONE = 2'b00,
      BUS_RD   = 2'b01,
      BUS_UPGR = 2'b10,
      BUS_RDX  = 2'b11
   } bus_op_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WB_REQ = 3'd1,
      GAP    = 3'd2,
      REQ    = 3'd3,
      WAIT   = 3'd4,
      RESP   = 3'd5
   } master_state_t;

endpackage

// File: rtl/wait_timer.sv
// Purpose: bus response watchdog; clear loads zero, inc counts up, expired at LIMIT-1.
// Latency: expired is decoded from the registered count (no input-to-output path).
// Backpressure: none; the counter holds at LIMIT-1 until cleared.
// Ports: clk, reset (async active-high), clr (load zero, wins over inc),
//        inc (count enable), expired (count == LIMIT-1).
module wait_timer #(
   parameter int LIMIT = 64,
   parameter int CW    = $clog2(LIMIT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/l1_bus_master.sv
// Purpose: per-core bus initiator turning an L1 miss/upgrade (plus optional victim writeback) into a req/grant transaction.
// Latency: accept -> resp_valid in 3 cycles minimum; writeback adds >=1 WB_REQ cycle plus one GAP cycle.
// Backpressure: miss_ready is low from accept until the cycle after the one-cycle resp_valid pulse.
// Ports: L1 side  miss_valid/miss_ready/miss_op/miss_addr/miss_opcode, wb_needed/wb_addr/wb_data,
//                 resp_valid/resp_data/resp_shared/resp_error.
//        Bus side req_core/grant, bus_operation_out/bus_address_out/bus_data_out, opcode_out,
//                 data_to_L2, flush_out, bus_resp_valid/bus_data_in/cache_hit_in.
module l1_bus_master
   import bus_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WAIT_LIMIT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miss_valid,
   output logic              miss_ready,
   input  logic [1:0]        miss_op,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic [6:0]        miss_opcode,
   input  logic              wb_needed,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_shared,
   output logic              resp_error,
   output logic              req_core,
   input  logic              grant,
   output logic [1:0]        bus_operation_out,
   output logic [ADDR_W-1:0] bus_address_out,
   output logic [DATA_W-1:0] bus_data_out,
   output logic [6:0]        opcode_out,
   output logic [DATA_W-1:0] data_to_L2,
   output logic              flush_out,
   input  logic              bus_resp_valid,
   input  logic [DATA_W-1:0] bus_data_in,
   input  logic              cache_hit_in
);

   master_state_t     state_q, state_d;
   bus_op_t           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_shared_q, resp_shared_d;
   logic              resp_error_q, resp_error_d;
   logic              wait_expired;

   // Counter sits at zero outside WAIT, so both the first grant and a retry
   // after a dropped grant start the window from 0.
   wait_timer #(
      .LIMIT (WAIT_LIMIT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_q != WAIT),
      .inc     (state_q == WAIT),
      .expired (wait_expired)
   );

   // Next-state and capture logic.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      opcode_d      = opcode_q;
      wb_addr_d     = wb_addr_q;
      wb_data_d     = wb_data_q;
      resp_data_d   = resp_data_q;
      resp_shared_d = resp_shared_q;
      resp_error_d  = resp_error_q;
      case (state_q)
         IDLE: begin
            if (miss_valid) begin
               op_d          = bus_op_t'(miss_op);
               addr_d        = miss_addr;
               opcode_d      = miss_opcode;
               wb_addr_d     = wb_addr;
               wb_data_d     = wb_data;
               resp_data_d   = '0;
               resp_shared_d = 1'b0;
               resp_error_d  = 1'b0;
               // A no-op request has nothing to fetch and completes at once.
               if (bus_op_t'(miss_op) == BUS_NONE) begin
                  state_d = RESP;
               end else if (wb_needed) begin
                  state_d = WB_REQ;
               end else begin
                  state_d = REQ;
               end
            end
         end
         WB_REQ: begin
            if (grant) state_d = GAP;
         end
         GAP: begin
            state_d = REQ;
         end
         REQ: begin
            if (grant) state_d = WAIT;
         end
         WAIT: begin
            // Response beats a simultaneous grant drop; a drop beats the timeout.
            if (bus_resp_valid) begin
               resp_data_d   = (op_q == BUS_UPGR) ? '0 : bus_data_in;
               resp_shared_d = cache_hit_in;
               resp_error_d  = 1'b0;
               state_d       = RESP;
            end else if (!grant) begin
               state_d = REQ;
            end else if (wait_expired) begin
               resp_data_d   = '0;
               resp_shared_d = 1'b0;
               resp_error_d  = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      // Held low during reset so L1 never sees a ready it cannot use.
      miss_ready        = (state_q == IDLE) && !reset;
      resp_valid        = (state_q == RESP);
      resp_data         = '0;
      resp_shared       = 1'b0;
      resp_error        = 1'b0;
      req_core          = 1'b0;
      bus_operation_out = BUS_NONE;
      bus_address_out   = '0;
      bus_data_out      = '0;
      opcode_out        = '0;
      data_to_L2        = '0;
      flush_out         = 1'b0;
      if (state_q == RESP) begin
         resp_data   = resp_data_q;
         resp_shared = resp_shared_q;
         resp_error  = resp_error_q;
      end
      case (state_q)
         WB_REQ: begin
            req_core          = 1'b1;
            flush_out         = 1'b1;
            bus_operation_out = BUS_NONE;
            bus_address_out   = wb_addr_q;
            bus_data_out      = wb_data_q;
            data_to_L2        = wb_data_q;
            opcode_out        = OP_STORE;
         end
         REQ, WAIT: begin
            req_core          = 1'b1;
            bus_operation_out = op_q;
            bus_address_out   = addr_q;
            opcode_out        = opcode_q;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= BUS_NONE;
         addr_q        <= '0;
         opcode_q      <= '0;
         wb_addr_q     <= '0;
         wb_data_q     <= '0;
         resp_data_q   <= '0;
         resp_shared_q <= 1'b0;
         resp_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         opcode_q      <= opcode_d;
         wb_addr_q     <= wb_addr_d;
         wb_data_q     <= wb_data_d;
         resp_data_q   <= resp_data_d;
         resp_shared_q <= resp_shared_d;
         resp_error_q  <= resp_error_d;
      end
   end

endmodule

// File: tb/tb_l1_bus_master.sv
// Purpose: directed bench for l1_bus_master with a response scoreboard.
// Latency: expected completion cycle is recorded per request and compared on resp_valid.
// Backpressure: grant withheld/dropped to exercise retry and timeout.
module tb_l1_bus_master;
   import bus_pkg::*;

   localparam int WL = 16;

   logic        clk;
   logic        reset;
   logic        miss_valid;
   logic        miss_ready;
   logic [1:0]  miss_op;
   logic [31:0] miss_addr;
   logic [6:0]  miss_opcode;
   logic        wb_needed;
   logic [31:0] wb_addr;
   logic [31:0] wb_data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_shared;
   logic        resp_error;
   logic        req_core;
   logic        grant;
   logic [1:0]  bus_operation_out;
   logic [31:0] bus_address_out;
   logic [31:0] bus_data_out;
   logic [6:0]  opcode_out;
   logic [31:0] data_to_L2;
   logic        flush_out;
   logic        bus_resp_valid;
   logic [31:0] bus_data_in;
   logic        cache_hit_in;

   l1_bus_master #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .WAIT_LIMIT (WL)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .miss_valid        (miss_valid),
      .miss_ready        (miss_ready),
      .miss_op           (miss_op),
      .miss_addr         (miss_addr),
      .miss_opcode       (miss_opcode),
      .wb_needed         (wb_needed),
      .wb_addr           (wb_addr),
      .wb_data           (wb_data),
      .resp_valid        (resp_valid),
      .resp_data         (resp_data),
      .resp_shared       (resp_shared),
      .resp_error        (resp_error),
      .req_core          (req_core),
      .grant             (grant),
      .bus_operation_out (bus_operation_out),
      .bus_address_out   (bus_address_out),
      .bus_data_out      (bus_data_out),
      .opcode_out        (opcode_out),
      .data_to_L2        (data_to_L2),
      .flush_out         (flush_out),
      .bus_resp_valid    (bus_resp_valid),
      .bus_data_in       (bus_data_in),
      .cache_hit_in      (cache_hit_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        shared;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every completion pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (resp_valid !== 1'b0) begin : pop
         exp_t e;
         if (sb.size() == 0) begin
            chk("spurious_resp_valid", 32'(resp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_data",   resp_data,          e.data);
            chk("resp_shared", 32'(resp_shared),   32'(e.shared));
            chk("resp_error",  32'(resp_error),    32'(e.err));
            chk("resp_cycle",  32'(cyc),           32'(e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle; c0 is the accept cycle.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [6:0] oc,
                        input logic wb, input logic [31:0] wa, input logic [31:0] wd,
                        output int c0);
      chk("miss_ready_idle", 32'(miss_ready), 32'd1);
      c0          = cyc;
      miss_valid  = 1'b1;
      miss_op     = op;
      miss_addr   = a;
      miss_opcode = oc;
      wb_needed   = wb;
      wb_addr     = wa;
      wb_data     = wd;
      step();
      miss_valid  = 1'b0;
      wb_needed   = 1'b0;
   endtask

   initial begin : stim
      int c0;
      reset          = 1'b1;
      miss_valid     = 1'b0;
      miss_op        = 2'b00;
      miss_addr      = '0;
      miss_opcode    = '0;
      wb_needed      = 1'b0;
      wb_addr        = '0;
      wb_data        = '0;
      grant          = 1'b0;
      bus_resp_valid = 1'b0;
      bus_data_in    = '0;
      cache_hit_in   = 1'b0;
      #1;
      chk("reset_miss_ready", 32'(miss_ready), 32'd0);
      chk("reset_req_core",   32'(req_core),   32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_bus_addr",   bus_address_out, 32'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("post_reset_miss_ready", 32'(miss_ready), 32'd1);

      // 1: BUS_RD, minimum latency, shared fill.
      issue(BUS_RD, 32'h100, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'hDEADBEEF, 1'b1, 1'b0, c0 + 3});
      chk("rd_req_core",   32'(req_core),          32'd1);
      chk("rd_bus_op",     32'(bus_operation_out), 32'd1);
      chk("rd_bus_addr",   bus_address_out,        32'h100);
      chk("rd_opcode",     32'(opcode_out),        32'h03);
      chk("rd_flush",      32'(flush_out),         32'd0);
      chk("rd_miss_ready", 32'(miss_ready),        32'd0);
      grant = 1'b1;
      step();
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'hDEADBEEF;
      cache_hit_in   = 1'b1;
      step();
      bus_resp_valid = 1'b0;
      grant          = 1'b0;
      chk("rd_resp_req_core", 32'(req_core),          32'd0);
      chk("rd_resp_bus_op",   32'(bus_operation_out), 32'd0);
      step();

      // 2: writeback then BUS_RDX; stray bus_resp_valid during WB_REQ is ignored.
      issue(BUS_RDX, 32'h300, OP_STORE, 1'b1, 32'h200, 32'h12345678, c0);
      sb.push_back('{32'hCAFEF00D, 1'b0, 1'b0, c0 + 6});
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'h99999999;
      chk("wb_req_core",   32'(req_core),          32'd1);
      chk("wb_flush",      32'(flush_out),         32'd1);
      chk("wb_bus_op",     32'(bus_operation_out), 32'd0);
      chk("wb_bus_addr",   bus_address_out,        32'h200);
      chk("wb_data_to_L2", data_to_L2,             32'h12345678);
      chk("wb_bus_data",   bus_data_out,           32'h12345678);
      chk("wb_opcode",     32'(opcode_out),        32'h23);
      step();
      bus_resp_valid = 1'b0;
      chk("wb_hold_req_core", 32'(req_core),  32'd1);
      chk("wb_hold_flush",    32'(flush_out), 32'd1);
      grant = 1'b1;
      step();
      grant = 1'b0;
      chk("gap_req_core", 32'(req_core),  32'd0);
      chk("gap_flush",    32'(flush_out), 32'd0);
      step();
      chk("rdx_req_core", 32'(req_core),          32'd1);
      chk("rdx_bus_op",   32'(bus_operation_out), 32'd3);
      chk("rdx_bus_addr", bus_address_out,        32'h300);
      chk("rdx_flush",    32'(flush_out),         32'd0);
      grant = 1'b1;
      step();
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'hCAFEF00D;
      cache_hit_in   = 1'b0;
      step();
      bus_resp_valid = 1'b0;
      grant          = 1'b0;
      step();

      // 3: BUS_UPGR; grant falls in the same cycle as the response.
      issue(BUS_UPGR, 32'h40, OP_STORE, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h0, 1'b0, 1'b0, c0 + 3});
      chk("upgr_bus_op", 32'(bus_operation_out), 32'd2);
      grant = 1'b1;
      step();
      grant          = 1'b0;
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'h55555555;
      cache_hit_in   = 1'b0;
      step();
      bus_resp_valid = 1'b0;
      step();

      // 4: grant withheld 10 cycles, then held with no response -> timeout.
      issue(BUS_RD, 32'h500, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h0, 1'b0, 1'b1, c0 + 11 + WL});
      bus_data_in  = 32'hFFFFFFFF;
      cache_hit_in = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         chk("to_req_core_req", 32'(req_core), 32'd1);
         if (i == 10) grant = 1'b1;
         step();
      end
      for (int i = 0; i < WL; i++) begin
         chk("to_req_core_wait", 32'(req_core), 32'd1);
         step();
      end
      grant = 1'b0;
      chk("to_resp_req_core", 32'(req_core), 32'd0);
      step();

      // 5: grant drops in WAIT at cycle 3, re-granted at 6, response at 7.
      issue(BUS_RD, 32'h580, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h0BADF00D, 1'b1, 1'b0, c0 + 8});
      grant = 1'b1;
      step();
      step();
      grant = 1'b0;
      step();
      chk("retry_req_core", 32'(req_core),          32'd1);
      chk("retry_bus_op",   32'(bus_operation_out), 32'd1);
      step();
      step();
      grant = 1'b1;
      step();
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'h0BADF00D;
      cache_hit_in   = 1'b1;
      step();
      bus_resp_valid = 1'b0;
      grant          = 1'b0;
      step();

      // 6: retry late in the window; timeout must count a full window from re-entry.
      issue(BUS_RD, 32'h600, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h0, 1'b0, 1'b1, c0 + 2 * WL + 2});
      grant = 1'b1;
      step();
      for (int i = 0; i < WL - 2; i++) step();
      grant = 1'b0;
      step();
      chk("late_retry_req_core", 32'(req_core), 32'd1);
      grant = 1'b1;
      step();
      for (int i = 0; i < WL; i++) step();
      grant = 1'b0;
      step();

      // 7: BUS_NONE completes without touching the bus.
      issue(BUS_NONE, 32'h700, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h0, 1'b0, 1'b0, c0 + 1});
      chk("none_req_core", 32'(req_core), 32'd0);
      step();

      // 8: reset in WAIT aborts with no completion.
      issue(BUS_RDX, 32'h800, OP_STORE, 1'b0, 32'h0, 32'h0, c0);
      grant = 1'b1;
      step();
      step();
      reset = 1'b1;
      #1;
      chk("rst_req_core",   32'(req_core),          32'd0);
      chk("rst_bus_op",     32'(bus_operation_out), 32'd0);
      chk("rst_bus_addr",   bus_address_out,        32'd0);
      chk("rst_resp_valid", 32'(resp_valid),        32'd0);
      grant = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rst_miss_ready", 32'(miss_ready), 32'd1);

      // 9: normal transaction after the abort.
      issue(BUS_RD, 32'h900, OP_LOAD, 1'b0, 32'h0, 32'h0, c0);
      sb.push_back('{32'h600DCAFE, 1'b0, 1'b0, c0 + 3});
      chk("post_rst_bus_addr", bus_address_out, 32'h900);
      grant = 1'b1;
      step();
      bus_resp_valid = 1'b1;
      bus_data_in    = 32'h600DCAFE;
      cache_hit_in   = 1'b0;
      step();
      bus_resp_valid = 1'b0;
      grant          = 1'b0;
      step();
      chk("final_miss_ready", 32'(miss_ready), 32'd1);

      repeat (3) step();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
